// File: rtl/stream_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for stream_rr_arbiter.
package stream_arb_pkg;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_REQ    = 16;
  localparam int IDX_W      = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // First asserted valid at ptr+1, ptr+2, ... modulo n; the lowest offset wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input int                 n);
    pick_t r;
    int    j;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = IDX_W'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_out_slice.sv
// One-entry registered valid/ready output slice with synchronous flush.
module arb_out_slice #(
  parameter type BEAT_T = logic
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  flush,
  input  logic  in_valid,
  input  BEAT_T in_beat,
  output logic  slice_ready,
  output logic  out_valid,
  input  logic  out_ready,
  output BEAT_T out_beat
);

  logic  vld_p1;
  BEAT_T beat_p1;

  assign slice_ready = !vld_p1 || out_ready;
  assign out_valid   = vld_p1;
  assign out_beat    = beat_p1;

  // Stage p1: in_valid is only raised when slice_ready, so a load may overlap a drain.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      beat_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
    end else if (in_valid) begin
      vld_p1  <= 1'b1;
      beat_p1 <= in_beat;
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin N_REQ-to-1 valid/ready stream arbiter with a registered output slice.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant on one requester until its last beat.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush_in,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_last,
  output logic [N_REQ-1:0]        grant,
  output logic                    locked
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ID_W-1:0]   id;
    logic              last;
  } arb_beat_t;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            accept;
  logic            slice_ready;
  pick_t           pick;
  arb_beat_t       in_beat;
  arb_beat_t       out_beat;

`ifdef STREAM_ARB_PKT_LOCK_EN
  logic            locked_q;
  logic [ID_W-1:0] lock_id_q;
`endif

  always_comb begin
    pick   = rr_pick(MAX_REQ'(req_valid), IDX_W'(ptr), N_REQ);
    winner = ID_W'(pick.idx);
    found  = pick.found;
`ifdef STREAM_ARB_PKT_LOCK_EN
    if (locked_q) begin
      winner = lock_id_q;
      found  = req_valid[lock_id_q];
    end
`endif
    accept = found && slice_ready && !flush_in && !reset;
    grant  = '0;
    if (accept) grant[winner] = 1'b1;
  end

  assign req_ready    = grant;
  assign in_beat.data = req_data[int'(winner)*DATA_W +: DATA_W];
  assign in_beat.id   = winner;
  assign in_beat.last = req_last[winner];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= ID_W'(N_REQ - 1);
`ifdef STREAM_ARB_PKT_LOCK_EN
    end else if (accept && req_last[winner]) begin
`else
    end else if (accept) begin
`endif
      ptr <= winner;
    end
  end

`ifdef STREAM_ARB_PKT_LOCK_EN
  // A non-last beat pins arbitration to its source until that source sends last.
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      locked_q <= 1'b0;
    end else if (accept) begin
      locked_q <= !req_last[winner];
      if (!req_last[winner]) lock_id_q <= winner;
    end
  end
  assign locked = locked_q;
`else
  assign locked = 1'b0;
`endif

  arb_out_slice #(.BEAT_T(arb_beat_t)) u_slice (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush_in),
    .in_valid    (accept),
    .in_beat     (in_beat),
    .slice_ready (slice_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_beat    (out_beat)
  );

  assign out_data = out_beat.data;
  assign out_id   = out_beat.id;
  assign out_last = out_beat.last;

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one elastic valid/ready output stream between N_REQ upstream requesters using round-robin arbitration.
- Sits in front of a downstream pipeline stage that accepts one beat per cycle.
- Registers the winning beat, with its source ID and last flag, in a one-entry output slice.
- Supports a synchronous flush that clears all in-flight state.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 8, payload width per requester.
- ID_W, $clog2(N_REQ), width of the source ID carried with each output beat.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush_in  in  1  synchronous flush; drops the held beat and any lock.
- req_valid  in  N_REQ  per-requester valid.
- req_ready  out  N_REQ  per-requester ready (one-hot or zero).
- req_data  in  N_REQ*DATA_W  packed payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  per-requester end-of-packet flag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream ready.
- out_data  out  DATA_W  output payload.
- out_id  out  ID_W  index of the requester that sourced out_data.
- out_last  out  1  last flag of the output beat.
- grant  out  N_REQ  one-hot requester accepted this cycle (debug).
- locked  out  1  packet lock active; always 0 when the lock feature is compiled out.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_id=0, out_last=0, locked=0.
  - Priority pointer ptr=N_REQ-1, so requester 0 has first priority.
- Slice accept: slice_ready = !out_valid || out_ready. The output slice can take a new beat in the same cycle the held beat drains.
- Arbitration:
  - Combinational each cycle.
  - The winner is the first asserted req_valid scanning ptr+1, ptr+2, ... with wrap-around modulo N_REQ.
  - If ptr+1 == N_REQ, the scan starts at 0.
- Grant and handshake:
  - grant[i] = winner==i && req_valid[i] && slice_ready && !flush_in.
  - req_ready = grant.
  - Only one requester is ever ready.
  - req_ready of non-winners is 0 regardless of their valid.
  - req_ready may depend combinationally on req_valid and out_ready.
- On accept (|grant):
  - Next cycle out_valid=1, out_data=req_data[winner], out_id=winner, out_last=req_last[winner], ptr<=winner.
- On drain without accept (out_valid && out_ready && !|grant): out_valid<=0. out_data, out_id and out_last hold their old values.
- Stall: while out_valid && !out_ready, out_data, out_id and out_last are stable and no requester is ready.
- Latency and throughput: 1 cycle from accept to out_valid; full throughput of 1 beat per cycle when out_ready stays high.
- No requests: ptr unchanged, req_ready=0.
- Flush:
  - Takes priority over accept and drain.
  - out_valid<=0, lock cleared, req_ready forced to 0 in the flush cycle.
  - ptr is preserved.
  - The held beat is discarded even if out_ready=1 in the same cycle. The downstream must not count it.
- Reset mid-operation: same effect as flush, and additionally ptr returns to N_REQ-1.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- When defined:
  - Accepting a beat with req_last=0 sets locked=1 and lock_id=winner.
  - While locked, the winner is forced to lock_id. Other requesters get no grant even if lock_id is idle; gaps are allowed.
  - Accepting a beat from lock_id with req_last=1 clears the lock.
  - ptr updates only when a last beat is accepted.
  - flush_in and reset clear the lock.
- When undefined:
  - Arbitration is per beat, ptr updates on every accept, and locked is tied to 0.
  - req_last is passed through to out_last only.

Decomposition:
- Package stream_arb_pkg holds:
  - the function rr_pick(valid, ptr), returning the index and a found flag;
  - the localparam default widths;
  - the typedef arb_beat_t {data, id, last}, parameterised via a DATA_W/ID_W struct in the module.
- Natural sub-module: arb_out_slice, a one-entry registered valid/ready slice with flush.
  - It holds arb_beat_t and exposes slice_ready.
  - The arbiter core owns ptr, the lock and the grant logic.

Test Plan:
1. Reset, then all four requesters hold valid with data 0x10,0x11,0x12,0x13 and out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_id 0,1,2,3 one cycle later; no idle cycles.
2. Only req 2 valid for 3 beats (0xA0..0xA2), then req 1 joins -> req 2 gets 3 beats, then req 1 wins because scanning starts at 3 and wraps 3,0,1.
3. Beat from req 0 held with out_ready=0 for 5 cycles while req 1 and req 3 are valid -> out_data stable, req_ready=0; when out_ready rises, the held beat drains and req 1 is granted the same cycle.
4. flush_in pulsed while out_valid=1 and out_ready=1 -> out_valid=0 next cycle, no grant in the flush cycle, ptr unchanged (next winner continues from the previous ptr).
5. With STREAM_ARB_PKT_LOCK_EN: req 1 sends a 3-beat packet (last on beat 3) with req 0 valid throughout -> locked=1 for beats 1-2, and req 0 is not granted until after req 1's last beat.
6. reset asserted mid-stream with out_valid=1 -> next cycle all outputs at reset values and the next grant goes to requester 0.
